// File: rtl/dp_neuron_scheduler.sv
// Dot-product sequencer: clears, streams, drains and captures each output neuron,
// keeping a running signed argmax that is published on a one-cycle done pulse.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_CLEAR   | dp_clear held, datapath accumulators reset
// S_STREAM  | pixel/weight chunks presented, one element per cycle
// S_DRAIN   | zero buses while the multiply/add pipeline empties
// S_CAPTURE | sample dp_value, update running max
// S_DONE    | result published, done pulse
module dp_neuron_scheduler #(
    parameter int NEURONS      = 10,
    parameter int PIXEL_N      = 785,
    parameter int BUS_WIDTH    = 196,
    parameter int VAL_SIZE     = 26,
    parameter int CLEAR_CYCLES = 2,
    parameter int DRAIN_CYCLES = 12,
    localparam int NUM_CHUNKS  = (PIXEL_N + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int CHUNK_W     = $clog2(NUM_CHUNKS + 1),
    localparam int NEUR_W      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                start,
    input  logic                abort,
    input  logic [VAL_SIZE-1:0] dp_value,
    output logic                dp_clear,
    output logic [CHUNK_W-1:0]  chunk_idx,
    output logic [NEUR_W-1:0]   neuron_idx,
    output logic                zero_fill,
    output logic                busy,
    output logic                done,
    output logic [NEUR_W-1:0]   class_out,
    output logic [VAL_SIZE-1:0] max_value
);

    localparam int TMR_MAX_A = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > BUS_WIDTH) ? TMR_MAX_A : BUS_WIDTH;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_CAPTURE, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [TMR_W-1:0]    r_tmr, w_tmr_nxt;
    logic [CHUNK_W-1:0]  r_chunk, w_chunk_nxt;
    logic [NEUR_W-1:0]   r_neuron, w_neuron_nxt;
    logic [VAL_SIZE-1:0] r_best_val, w_best_val_nxt;
    logic [NEUR_W-1:0]   r_best_idx, w_best_idx_nxt;
    logic                r_best_vld, w_best_vld_nxt;
    logic [NEUR_W-1:0]   r_class, w_class_nxt;
    logic [VAL_SIZE-1:0] r_max, w_max_nxt;
    logic                r_dp_clear, r_zero_fill, r_busy, r_done;
    logic                w_tmr_tc, w_last_chunk, w_last_neuron, w_take;

    assign w_tmr_tc      = (r_tmr == '0);
    assign w_last_chunk  = (r_chunk == CHUNK_W'(NUM_CHUNKS - 1));
    assign w_last_neuron = (r_neuron == NEUR_W'(NEURONS - 1));
    // strict greater-than so a tie keeps the earlier (lower) neuron index
    assign w_take        = !r_best_vld || ($signed(dp_value) > $signed(r_best_val));

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start && !abort) w_state_nxt = S_CLEAR;
            S_CLEAR:   if (abort) w_state_nxt = S_IDLE;
                       else if (w_tmr_tc) w_state_nxt = S_STREAM;
            S_STREAM:  if (abort) w_state_nxt = S_IDLE;
                       else if (w_tmr_tc && w_last_chunk) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (abort) w_state_nxt = S_IDLE;
                       else if (w_tmr_tc) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (abort) w_state_nxt = S_IDLE;
                       else if (w_last_neuron) w_state_nxt = S_DONE;
                       else w_state_nxt = S_CLEAR;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tmr_nxt      = r_tmr;
        w_chunk_nxt    = r_chunk;
        w_neuron_nxt   = r_neuron;
        w_best_val_nxt = r_best_val;
        w_best_idx_nxt = r_best_idx;
        w_best_vld_nxt = r_best_vld;
        w_class_nxt    = r_class;
        w_max_nxt      = r_max;
        case (r_state)
            S_IDLE: begin
                if (w_state_nxt == S_CLEAR) begin
                    w_tmr_nxt      = TMR_W'(CLEAR_CYCLES - 1);
                    w_chunk_nxt    = '0;
                    w_neuron_nxt   = '0;
                    w_best_vld_nxt = 1'b0;
                end
            end
            S_CLEAR: begin
                if (w_state_nxt == S_STREAM) w_tmr_nxt = TMR_W'(BUS_WIDTH - 1);
                else if (w_state_nxt == S_CLEAR) w_tmr_nxt = r_tmr - 1'b1;
            end
            S_STREAM: begin
                if (w_state_nxt == S_DRAIN) begin
                    w_chunk_nxt = CHUNK_W'(NUM_CHUNKS);
                    w_tmr_nxt   = TMR_W'(DRAIN_CYCLES - 1);
                end else if (w_state_nxt == S_STREAM) begin
                    if (w_tmr_tc) begin
                        w_chunk_nxt = r_chunk + 1'b1;
                        w_tmr_nxt   = TMR_W'(BUS_WIDTH - 1);
                    end else begin
                        w_tmr_nxt = r_tmr - 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (w_state_nxt == S_DRAIN) w_tmr_nxt = r_tmr - 1'b1;
            end
            S_CAPTURE: begin
                if (w_state_nxt != S_IDLE && w_take) begin
                    w_best_val_nxt = dp_value;
                    w_best_idx_nxt = r_neuron;
                    w_best_vld_nxt = 1'b1;
                end
                if (w_state_nxt == S_CLEAR) begin
                    w_neuron_nxt = r_neuron + 1'b1;
                    w_chunk_nxt  = '0;
                    w_tmr_nxt    = TMR_W'(CLEAR_CYCLES - 1);
                end else if (w_state_nxt == S_DONE) begin
                    w_class_nxt = w_take ? r_neuron : r_best_idx;
                    w_max_nxt   = w_take ? dp_value : r_best_val;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            r_tmr       <= '0;
            r_chunk     <= '0;
            r_neuron    <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_best_vld  <= 1'b0;
            r_class     <= '0;
            r_max       <= '0;
            r_dp_clear  <= 1'b0;
            r_zero_fill <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_tmr       <= w_tmr_nxt;
            r_chunk     <= w_chunk_nxt;
            r_neuron    <= w_neuron_nxt;
            r_best_val  <= w_best_val_nxt;
            r_best_idx  <= w_best_idx_nxt;
            r_best_vld  <= w_best_vld_nxt;
            r_class     <= w_class_nxt;
            r_max       <= w_max_nxt;
            r_dp_clear  <= (w_state_nxt == S_CLEAR);
            r_zero_fill <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_DRAIN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign dp_clear   = r_dp_clear;
    assign chunk_idx  = r_chunk;
    assign neuron_idx = r_neuron;
    assign zero_fill  = r_zero_fill;
    assign busy       = r_busy;
    assign done       = r_done;
    assign class_out  = r_class;
    assign max_value  = r_max;

endmodule

// File: tb/tb_dp_neuron_scheduler.sv
// Directed bench for dp_neuron_scheduler: a small configuration checked cycle by cycle,
// plus one default-parameter instance for end-to-end latency.
module tb_dp_neuron_scheduler;

    logic        clk;
    logic        GlobalReset;
    logic        start;
    logic        abort;
    logic [25:0] dp_value;
    logic        dp_clear;
    logic [1:0]  chunk_idx;
    logic [1:0]  neuron_idx;
    logic        zero_fill;
    logic        busy;
    logic        done;
    logic [1:0]  class_out;
    logic [25:0] max_value;

    logic        d_start;
    logic        d_abort;
    logic [25:0] d_dp_value;
    logic        d_dp_clear;
    logic [2:0]  d_chunk_idx;
    logic [3:0]  d_neuron_idx;
    logic        d_zero_fill;
    logic        d_busy;
    logic        d_done;
    logic [3:0]  d_class_out;
    logic [25:0] d_max_value;

    logic signed [25:0] vals [3];
    int checks;
    int failures;

    dp_neuron_scheduler #(
        .NEURONS(3), .PIXEL_N(10), .BUS_WIDTH(4), .VAL_SIZE(26),
        .CLEAR_CYCLES(2), .DRAIN_CYCLES(3)
    ) u_dut (
        .clk(clk), .GlobalReset(GlobalReset), .start(start), .abort(abort),
        .dp_value(dp_value), .dp_clear(dp_clear), .chunk_idx(chunk_idx),
        .neuron_idx(neuron_idx), .zero_fill(zero_fill), .busy(busy), .done(done),
        .class_out(class_out), .max_value(max_value)
    );

    dp_neuron_scheduler u_dut_def (
        .clk(clk), .GlobalReset(GlobalReset), .start(d_start), .abort(d_abort),
        .dp_value(d_dp_value), .dp_clear(d_dp_clear), .chunk_idx(d_chunk_idx),
        .neuron_idx(d_neuron_idx), .zero_fill(d_zero_fill), .busy(d_busy), .done(d_done),
        .class_out(d_class_out), .max_value(d_max_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath stand-in: result depends only on which neuron is being evaluated
    always_comb begin
        dp_value = '0;
        if (neuron_idx < 2'd3) dp_value = vals[neuron_idx];
    end

    assign d_dp_value = 26'd42;

    task automatic test_reset();
        #3;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (dp_clear !== 1'b0) begin failures++; $display("FAIL reset_dp_clear got=%b exp=0", dp_clear); end
        checks++; if (chunk_idx !== 2'd0) begin failures++; $display("FAIL reset_chunk got=%0d exp=0", chunk_idx); end
        checks++; if (class_out !== 2'd0 || max_value !== 26'd0) begin
            failures++; $display("FAIL reset_result got=%0d/%0d exp=0/0", class_out, max_value); end
        @(negedge clk); GlobalReset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    // full run of the small config; extra_k/abort_k = cycle index to pulse start/abort (0 = none)
    task automatic run_small(input logic signed [25:0] a, input logic signed [25:0] b,
                             input logic signed [25:0] c, input int extra_k, input int abort_k,
                             input logic [1:0] exp_cls, input logic signed [25:0] exp_max,
                             input string tag);
        int  ndone;
        int  p;
        int  n;
        bit  live;
        bit  exp_done;
        vals[0] = a; vals[1] = b; vals[2] = c;
        ndone = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            if (k > 1) @(negedge clk);
            if (k == extra_k + 1) start = 1'b0;
            if (k == abort_k + 1) abort = 1'b0;
            live     = (abort_k == 0) ? (k <= 55) : (k <= abort_k);
            exp_done = (abort_k == 0) && (k == 55);
            checks++; if (busy !== live) begin
                failures++; $display("FAIL %s_busy k=%0d got=%b exp=%b", tag, k, busy, live); end
            checks++; if (done !== exp_done) begin
                failures++; $display("FAIL %s_done k=%0d got=%b exp=%b", tag, k, done, exp_done); end
            if (done === 1'b1) ndone++;
            if (live && k <= 54) begin
                p = (k - 1) % 18;
                n = (k - 1) / 18;
                checks++; if (neuron_idx !== 2'(n)) begin
                    failures++; $display("FAIL %s_neuron k=%0d got=%0d exp=%0d", tag, k, neuron_idx, n); end
                checks++; if (dp_clear !== (p < 2)) begin
                    failures++; $display("FAIL %s_dp_clear k=%0d got=%b exp=%b", tag, k, dp_clear, (p < 2)); end
                if (p < 17) begin
                    checks++; if (zero_fill !== (p < 2 || p >= 14)) begin
                        failures++; $display("FAIL %s_zero_fill k=%0d got=%b", tag, k, zero_fill); end
                    checks++; if (chunk_idx !== 2'((p < 2) ? 0 : (p >= 14) ? 3 : (p - 2) / 4)) begin
                        failures++; $display("FAIL %s_chunk k=%0d got=%0d p=%0d", tag, k, chunk_idx, p); end
                end
            end else if (!live) begin
                checks++; if (dp_clear !== 1'b0 || zero_fill !== 1'b0) begin
                    failures++; $display("FAIL %s_idle_outs k=%0d got=%b%b exp=00", tag, k, dp_clear, zero_fill); end
            end
            if (k == extra_k) start = 1'b1;
            if (k == abort_k) abort = 1'b1;
        end
        checks++; if (ndone != ((abort_k == 0) ? 1 : 0)) begin
            failures++; $display("FAIL %s_done_count got=%0d", tag, ndone); end
        checks++; if (class_out !== exp_cls) begin
            failures++; $display("FAIL %s_class got=%0d exp=%0d", tag, class_out, exp_cls); end
        checks++; if (max_value !== exp_max) begin
            failures++; $display("FAIL %s_max got=%0d exp=%0d", tag, $signed(max_value), exp_max); end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || dp_clear !== 1'b0) begin
            failures++; $display("FAIL abort_start_idle got=%b%b exp=00", busy, dp_clear); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_start_idle2 got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        vals[0] = 26'sd1; vals[1] = 26'sd1; vals[2] = 26'sd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (busy !== 1'b1 || zero_fill !== 1'b0) begin
            failures++; $display("FAIL rstmid_pre got=%b%b exp=10", busy, zero_fill); end
        #2 GlobalReset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dp_clear !== 1'b0 || zero_fill !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl got=%b%b%b%b exp=0000", busy, done, dp_clear, zero_fill); end
        checks++; if (chunk_idx !== 2'd0 || neuron_idx !== 2'd0) begin
            failures++; $display("FAIL rstmid_idx got=%0d/%0d exp=0/0", chunk_idx, neuron_idx); end
        checks++; if (class_out !== 2'd0 || max_value !== 26'd0) begin
            failures++; $display("FAIL rstmid_result got=%0d/%0d exp=0/0", class_out, max_value); end
        @(negedge clk); GlobalReset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rstmid_post got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_defaults();
        int cnt;
        int max_chunk;
        max_chunk = 0;
        @(negedge clk); d_start = 1'b1;
        @(negedge clk); d_start = 1'b0;
        cnt = 1;
        while (d_done !== 1'b1 && cnt < 12000) begin
            if (int'(d_chunk_idx) > max_chunk) max_chunk = int'(d_chunk_idx);
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt != 9951) begin failures++; $display("FAIL def_latency got=%0d exp=9951", cnt); end
        checks++; if (max_chunk > 5) begin failures++; $display("FAIL def_chunk_max got=%0d exp<=5", max_chunk); end
        checks++; if (d_class_out !== 4'd0 || d_max_value !== 26'd42) begin
            failures++; $display("FAIL def_result got=%0d/%0d exp=0/42", d_class_out, d_max_value); end
        @(negedge clk);
        checks++; if (d_busy !== 1'b0 || d_done !== 1'b0) begin
            failures++; $display("FAIL def_idle got=%b%b exp=00", d_busy, d_done); end
    endtask

    initial begin
        checks = 0; failures = 0;
        GlobalReset = 1'b1; start = 1'b0; abort = 1'b0;
        d_start = 1'b0; d_abort = 1'b0;
        vals[0] = '0; vals[1] = '0; vals[2] = '0;
        test_reset();
        run_small(-26'sd5, 26'sd7, 26'sd3, 0, 0, 2'd1, 26'sd7, "timing");
        run_small(-26'sd2, -26'sd9, -26'sd2, 0, 0, 2'd0, -26'sd2, "tie_neg");
        run_small(26'sd4, 26'sd9, 26'sd9, 10, 0, 2'd1, 26'sd9, "start_busy");
        run_small(26'sd1, 26'sd2, 26'sd3, 0, 0, 2'd2, 26'sd3, "back_to_back");
        run_small(26'sd100, 26'sd200, 26'sd300, 0, 30, 2'd2, 26'sd3, "abort");
        test_abort_start_idle();
        test_reset_mid();
        test_defaults();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_neuron_scheduler.md
Name: dp_neuron_scheduler

Overview:
Sequencer for the dot-product datapath in the classifier. It walks all NEURONS output neurons. For each neuron it:
- clears the datapath accumulators,
- streams the pixel/weight vector as BUS_WIDTH-wide chunks,
- waits for the multiplier/adder pipeline to drain,
- captures the accumulated value.

A running signed argmax produces the final class index with a start/done handshake. It sits between the top-level control FSM, the pixel/weight memories (driven via chunk_idx/zero_fill) and the dot-product datapath.

Parameters:
NEURONS, 10, number of output neurons to evaluate
PIXEL_N, 785, vector length per neuron (pixels incl. bias)
BUS_WIDTH, 196, elements consumed per chunk; the datapath takes one element per cycle
VAL_SIZE, 26, width of datapath value (two's complement)
CLEAR_CYCLES, 2, cycles dp_clear is held per neuron (>=1)
DRAIN_CYCLES, 12, post-stream cycles before capture; covers FPM_DELAY+FPA_DELAY+register stages (>=1)
NUM_CHUNKS, ceil(PIXEL_N/BUS_WIDTH) = 5, derived localparam
CHUNK_W, clog2(NUM_CHUNKS+1), derived
NEUR_W, clog2(NEURONS), derived (min 1)

Ports:
clk  in  1  system clock, all logic on rising edge
GlobalReset  in  1  asynchronous, active-high reset
start  in  1  request a classification; sampled only in IDLE
abort  in  1  synchronous cancel of an in-progress run
dp_value  in  VAL_SIZE  accumulated dot-product value from the datapath
dp_clear  out  1  registered clear to datapath accumulators/counters
chunk_idx  out  CHUNK_W  chunk select for the pixel/weight memories
neuron_idx  out  NEUR_W  weight-bank select (current neuron)
zero_fill  out  1  memories must present all-zero buses this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: result valid
class_out  out  NEUR_W  argmax neuron index of last completed run
max_value  out  VAL_SIZE  dp_value of the winning neuron

Behaviour:
- Reset (GlobalReset high, async): state=IDLE. All outputs 0, including class_out, max_value, chunk_idx, neuron_idx. All counters 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, CLEAR, STREAM, DRAIN, CAPTURE, DONE.
- IDLE:
  - start=1 and abort=0 at an edge -> CLEAR, with neuron_idx=0 and the running max marked empty.
  - start while not in IDLE is ignored; requests are not queued.
- CLEAR:
  - dp_clear=1 for exactly CLEAR_CYCLES cycles, then -> STREAM with chunk_idx=0 and beat counter=0.
  - chunk_idx=0 and zero_fill=1 throughout.
- STREAM:
  - Beat counter runs 0..BUS_WIDTH-1 per chunk.
  - At beat BUS_WIDTH-1, chunk_idx increments.
  - After beat BUS_WIDTH-1 of chunk NUM_CHUNKS-1 -> DRAIN.
  - Duration is exactly NUM_CHUNKS*BUS_WIDTH cycles.
  - dp_clear=0 and zero_fill=0. Tail padding of the last chunk is the memory's responsibility.
- DRAIN:
  - zero_fill=1, chunk_idx=NUM_CHUNKS (out-of-range pad code).
  - Lasts DRAIN_CYCLES cycles, then -> CAPTURE.
- CAPTURE (1 cycle): sample dp_value.
  - If it is the first neuron, or dp_value > running max (signed compare), store value and neuron_idx.
  - Ties keep the lower index.
  - Then, if neuron_idx==NEURONS-1 -> DONE; else neuron_idx+1 and -> CLEAR.
- DONE (1 cycle):
  - done=1. class_out/max_value update on entry and hold until the next DONE.
  - Next state is IDLE. busy=1 in DONE and 0 in IDLE.
- Per-neuron latency: L = CLEAR_CYCLES + NUM_CHUNKS*BUS_WIDTH + DRAIN_CYCLES + 1 (defaults 995).
- Run latency: done is high in cycle NEURONS*L+1 after the edge that samples start.
- neuron_idx holds stable from CLEAR through CAPTURE of each neuron.
- abort=1 in any non-IDLE state:
  - -> IDLE at next edge; dp_clear=0, zero_fill=0, no done.
  - class_out/max_value keep the previous completed result.
  - abort with start in IDLE: abort wins, start is ignored.
- GlobalReset mid-run: immediate return to reset values. No done is produced.

Test Plan:
- Reset: assert GlobalReset mid-STREAM -> all outputs 0 asynchronously (before next clk edge); state IDLE; busy=0.
- Timing (NEURONS=3, PIXEL_N=10, BUS_WIDTH=4, CLEAR_CYCLES=2, DRAIN_CYCLES=3; NUM_CHUNKS=3, L=18):
  - start pulse -> done high exactly 55 cycles after the start-sampling edge.
  - dp_clear high 2 cycles per neuron; chunk_idx sequence 0×4,1×4,2×4,then 3×3 per neuron; busy high 55 cycles.
- Argmax: dp_value captured per neuron = -5, 7, 3 -> class_out=1, max_value=7 at done. Then -2, -9, -2 -> class_out=0, max_value=-2 (tie keeps lowest index; negative compare).
- Start while busy: second start pulse at cycle 10 -> ignored, a single done at cycle 55. Next start in IDLE is accepted normally.
- Abort: abort at cycle 30 -> busy=0 next cycle, no done pulse, class_out/max_value retain the prior run's result. abort+start together in IDLE -> stays IDLE.
- Defaults: default parameters, constant dp_value pattern -> done 9951 cycles after start; chunk_idx never exceeds 5.
